count_enable_gen: RTL and testbench
===================================

Name: count_enable_gen

Overview:
- Upstream control stage for the 4-bit synchronous counter; produces its `en` input.
- Turns a raw mechanical key plus a mode select into clean single-cycle count-enable pulses.
- Supports two modes:
  - step: one pulse per debounced key press.
  - run: free-running pulses at a programmable rate; a key press starts/stops the pulse train.
- Output `en` is registered and drives the counter's `en` directly.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable samples required before the debounced key level changes (>=2).
- RATE_W, 8, width of the run-mode rate input and prescaler.
- REPEAT_DELAY, 64, cycles a key must be held before auto-repeat starts (only with CNT_AUTOREPEAT_EN).
- REPEAT_RATE, 16, cycles between auto-repeat pulses (only with CNT_AUTOREPEAT_EN).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- clear  input  1  synchronous active-low reset, sampled on the clock rising edge.
- key_in  input  1  raw, asynchronous, bouncing key; high = pressed.
- run_mode  input  1  0 = step mode, 1 = run mode; synchronous, quasi-static.
- rate  input  RATE_W  run-mode period minus one; en fires every rate+1 cycles.
- en  output  1  registered count-enable pulse to the counter.
- key_level  output  1  debounced, synchronized key level.
- running  output  1  high while the run-mode pulse train is active.

Behaviour:
- Reset (clear=0 at an edge):
  - Synchronizer flops, debounce counter, key_level, prescaler, running and en all go to 0.
  - FSM goes to STEP.
  - clear has priority over all other events, including mid-pulse and mid-debounce.
- Synchronizer: key_in passes through 2 flops (s1, s2) before any other use.
- Debounce:
  - The counter increments while s2 != key_level and clears to 0 whenever s2 == key_level.
  - When the counter reaches DEBOUNCE_CYCLES, key_level takes the value of s2 and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes key_level.
- Press: press = key_level rising edge, using a registered copy of key_level.
- FSM states: STEP, RUN_IDLE, RUN_ACTIVE.
  - STEP: each press gives en=1 for exactly one cycle, the cycle after key_level rises. run_mode=1 moves to RUN_IDLE.
  - RUN_IDLE: on press, clear the prescaler, set running=1, move to RUN_ACTIVE. run_mode=0 moves to STEP.
  - RUN_ACTIVE:
    - The prescaler increments each cycle.
    - When prescaler >= rate, en=1 for one cycle and the prescaler clears.
    - The first en comes rate+1 cycles after entry. With rate=0, en is high every cycle.
    - A press moves to RUN_IDLE and clears running.
    - run_mode=0 moves to STEP, clears running and clears the prescaler.
- Simultaneous events:
  - A press in the same cycle as a prescaler terminal count: the stop wins and no en is issued.
  - A run_mode change in the same cycle as a press: the mode change wins and the press is dropped.
- Rate changes: a change of rate while in RUN_ACTIVE takes effect at the next compare. Because the compare is >=, a lowered rate never causes a missed wrap.
- Key release: produces no pulse in any mode.
- Latency: from the first edge that samples key_in high, held stable, en is high after edge 2+DEBOUNCE_CYCLES+1.

Optional Feature:
- Macro: CNT_AUTOREPEAT_EN.
- Defined:
  - In STEP, after the initial press pulse, if key_level stays high for REPEAT_DELAY cycles, en pulses once.
  - It then pulses every REPEAT_RATE cycles until key_level falls.
  - Release or leaving STEP clears the repeat counter.
- Undefined: exactly one pulse per press. The repeat counter and REPEAT_* parameters are unused and no logic is generated.

Decomposition:
- Shared package/include (cnt_ctrl_pkg): FSM state encodings (STEP=2'd0, RUN_IDLE=2'd1, RUN_ACTIVE=2'd2) and a debounce counter width constant derived from DEBOUNCE_CYCLES.
- One sub-module, key_debounce:
  - Contains the 2-flop synchronizer, debounce counter and key_level register.
  - Ports: clock, clear, key_in, key_level.
  - Parameter: DEBOUNCE_CYCLES.
- The FSM, prescaler and auto-repeat logic stay in count_enable_gen.

Test Plan:
- Reset: drive clear=0 for 2 cycles with key_in=1 and run_mode=1 → en=0, running=0, key_level=0; after release, key_level rises only after the full debounce time.
- Step press (DEBOUNCE_CYCLES=4, run_mode=0): key_in 0→1 held → en high for exactly one cycle, after the 7th edge; release → no pulse; 3 presses → counter reaches 3.
- Bounce: key_in toggles with periods of 1–3 cycles for 20 cycles, then holds high → key_level changes once and exactly one en pulse.
- Run mode (rate=3): press → running=1, en every 4th cycle; 3 pulses then press → running=0, no further en; with rate=0, en is continuously high.
- Priority: press on the terminal-count cycle → no en that cycle and running=0; clear=0 in RUN_ACTIVE mid-period → en=0 and state STEP next edge.
- Auto-repeat (CNT_AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_RATE=4): hold key → initial pulse, next pulse 8 cycles later, then every 4 cycles; release stops the pulses. With the macro undefined, the same stimulus gives exactly 1 pulse.

Source files
------------

// File: rtl/cnt_ctrl_pkg.sv
// Shared definitions for the counter control path: FSM encodings and width helpers.
// Latency: none (types, constants and elaboration-time functions only).
// Backpressure: none.
package cnt_ctrl_pkg;

  // Count-enable generator FSM states
  typedef enum logic [1:0] {
    STEP       = 2'd0,
    RUN_IDLE   = 2'd1,
    RUN_ACTIVE = 2'd2
  } cnt_state_t;

  // Default number of consecutive stable samples before the debounced level moves
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  // Debounce counter width: the counter only ever holds 0 .. DEBOUNCE_CYCLES-1
  function automatic int db_cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  // Auto-repeat counter width: holds 0 .. max(delay, rate)-1
  function automatic int rpt_cnt_w(input int dly, input int rt);
    int m;
    m = (dly > rt) ? dly : rt;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes a raw bouncing key and debounces it into a clean level.
// Latency: 2 sync flops plus DEBOUNCE_CYCLES stable samples before key_level moves.
// Backpressure: none; key_in is sampled every cycle.
module key_debounce
  import cnt_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic clear,
  input  logic key_in,
  output logic key_level
);

  localparam int            CW       = db_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous key input
  always_ff @(posedge clock) begin
    if (!clear) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  // Count consecutive samples that disagree with the current level; move the level on the last one
  always_ff @(posedge clock) begin
    if (!clear) begin
      cnt       <= '0;
      key_level <= 1'b0;
    end else if (s2 == key_level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      key_level <= s2;
      cnt       <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/count_enable_gen.sv
// Turns a debounced key and mode select into single-cycle count-enable pulses (step or free-run); CNT_AUTOREPEAT_EN adds held-key auto-repeat in step mode.
// Latency: en rises on edge 2+DEBOUNCE_CYCLES+1 after key_in is first sampled high; run-mode first pulse rate+1 cycles after start.
// Backpressure: none; en is a registered pulse the counter must accept every cycle it is high.
module count_enable_gen
  import cnt_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int RATE_W          = 8,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              key_in,
  input  logic              run_mode,
  input  logic [RATE_W-1:0] rate,
  output logic              en,
  output logic              key_level,
  output logic              running
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_RATE must be at least 1");
  end

  cnt_state_t        state;
  cnt_state_t        state_n;
  logic [RATE_W-1:0] presc;
  logic [RATE_W-1:0] presc_n;
  logic              running_n;
  logic              en_n;
  logic              key_level_q;
  logic              press;
  logic              rpt_fire;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clock     (clock),
    .clear     (clear),
    .key_in    (key_in),
    .key_level (key_level)
  );

  // A press is the rising edge of the debounced level; releases are ignored
  assign press = key_level & ~key_level_q;

`ifdef CNT_AUTOREPEAT_EN
  localparam int            RW       = rpt_cnt_w(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RT_LAST  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_armed;
  logic          rpt_fast;
  logic          rpt_hold;

  // Repeat only while the key is held in step mode and the FSM is not about to leave STEP
  assign rpt_hold = (state == STEP) && !run_mode && key_level;
  assign rpt_fire = rpt_hold && rpt_armed &&
                    (rpt_cnt == (rpt_fast ? RT_LAST : DLY_LAST));

  // Arm on the initial press, wait the long delay once, then repeat at the short rate
  always_ff @(posedge clock) begin
    if (!clear || !rpt_hold) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
      rpt_fast  <= 1'b0;
    end else if (press) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b1;
      rpt_fast  <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt  <= '0;
      rpt_fast <= 1'b1;
    end else if (rpt_armed) begin
      rpt_cnt <= rpt_cnt + RW'(1);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // State, prescaler, output registers and the press-edge history
  always_ff @(posedge clock) begin
    if (!clear) begin
      state       <= STEP;
      presc       <= '0;
      running     <= 1'b0;
      en          <= 1'b0;
      key_level_q <= 1'b0;
    end else begin
      state       <= state_n;
      presc       <= presc_n;
      running     <= running_n;
      en          <= en_n;
      key_level_q <= key_level;
    end
  end

  // Next-state decode; mode changes beat presses, and a stop press beats a terminal count
  always_comb begin
    state_n   = state;
    presc_n   = presc;
    running_n = running;
    en_n      = 1'b0;
    case (state)
      STEP: begin
        if (run_mode) begin
          state_n = RUN_IDLE;
        end else if (press || rpt_fire) begin
          en_n = 1'b1;
        end
      end
      RUN_IDLE: begin
        if (!run_mode) begin
          state_n = STEP;
        end else if (press) begin
          presc_n   = '0;
          running_n = 1'b1;
          state_n   = RUN_ACTIVE;
        end
      end
      RUN_ACTIVE: begin
        if (!run_mode) begin
          state_n   = STEP;
          running_n = 1'b0;
          presc_n   = '0;
        end else if (press) begin
          state_n   = RUN_IDLE;
          running_n = 1'b0;
          presc_n   = '0;
        end else if (presc >= rate) begin
          // >= so a rate lowered below the current count still wraps immediately
          en_n    = 1'b1;
          presc_n = '0;
        end else begin
          presc_n = presc + RATE_W'(1);
        end
      end
      default: begin
        state_n   = STEP;
        presc_n   = '0;
        running_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_count_enable_gen.sv
module tb_count_enable_gen;

  localparam int RATE_W = 8;

  logic              clock = 1'b0;
  logic              clear;
  logic              key_in;
  logic              run_mode;
  logic [RATE_W-1:0] rate;
  logic              en;
  logic              key_level;
  logic              running;

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   kl_rises = 0;
  logic kl_prev  = 1'b0;
  int   sb[$];
  int   bounce[10] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 2};

  count_enable_gen #(
    .DEBOUNCE_CYCLES (4),
    .RATE_W          (RATE_W),
    .REPEAT_DELAY    (8),
    .REPEAT_RATE     (4)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .key_in    (key_in),
    .run_mode  (run_mode),
    .rate      (rate),
    .en        (en),
    .key_level (key_level),
    .running   (running)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (after edge %0d)", name, act, exp, cyc);
  endtask

  // Pops the expected pulse edge whenever en is seen high; flags pulses that never came
  task automatic monitor();
    int e;
    forever begin
      @(negedge clock);
      if (key_level === 1'b1 && kl_prev !== 1'b1) kl_rises++;
      kl_prev = key_level;
      if (en === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL en_unexpected: pulse after edge %0d, none expected", cyc);
        end else begin
          e = sb.pop_front();
          if (e == cyc) n_pass++;
          else $display("FAIL en_timing: pulse after edge %0d, expected after edge %0d", cyc, e);
        end
      end else if (sb.size() > 0 && sb[0] <= cyc) begin
        n_checks++;
        e = sb.pop_front();
        $display("FAIL en_missing: no pulse after edge %0d, expected one", e);
      end
    end
  endtask

  initial begin
    int n;
    int kb;
    clear    = 1'b0;
    key_in   = 1'b1;
    run_mode = 1'b1;
    rate     = '0;
    fork
      monitor();
    join_none

    // Reset held two edges with key pressed and run mode selected
    step(2);
    check("rst_en", {31'd0, en}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_key_level", {31'd0, key_level}, 32'd0);

    // Release reset with key still held: full debounce, then one step pulse
    run_mode = 1'b0;
    clear    = 1'b1;
    n = cyc;
    sb.push_back(n + 7);
    step(5);
    check("post_rst_level_early", {31'd0, key_level}, 32'd0);
    step(1);
    check("post_rst_level_set", {31'd0, key_level}, 32'd1);
    key_in = 1'b0;
    step(10);
    check("release_level", {31'd0, key_level}, 32'd0);

    // Three clean step presses, one pulse each, none on release
    for (int i = 0; i < 3; i++) begin
      n = cyc;
      key_in = 1'b1;
      sb.push_back(n + 7);
      step(8);
      key_in = 1'b0;
      step(8);
    end

    // Bounce shorter than the debounce window, then a solid press
    kb = kl_rises;
    for (int i = 0; i < 10; i++) begin
      key_in = (i % 2 == 0);
      step(bounce[i]);
    end
    check("bounce_no_level", kl_rises - kb, 0);
    n = cyc;
    key_in = 1'b1;
    sb.push_back(n + 7);
    step(8);
    key_in = 1'b0;
    check("bounce_one_rise", kl_rises - kb, 1);
    step(8);

    // Run mode rate=3: three pulses every 4 cycles, then a stop press
    run_mode = 1'b1;
    rate     = 8'd3;
    step(2);
    n = cyc;
    key_in = 1'b1;
    sb.push_back(n + 11);
    sb.push_back(n + 15);
    sb.push_back(n + 19);
    step(7);
    check("run_started", {31'd0, running}, 32'd1);
    key_in = 1'b0;
    step(7);
    key_in = 1'b1;
    step(8);
    check("run_stopped", {31'd0, running}, 32'd0);
    key_in = 1'b0;
    step(12);

    // Rate 0: en high every cycle until run_mode drops
    rate = 8'd0;
    n = cyc;
    key_in = 1'b1;
    for (int i = 8; i <= 12; i++) sb.push_back(n + i);
    step(7);
    key_in = 1'b0;
    step(5);
    check("rate0_running", {31'd0, running}, 32'd1);
    run_mode = 1'b0;
    step(1);
    check("mode_exit_running", {31'd0, running}, 32'd0);
    step(10);

    // Stop press landing on the terminal-count cycle (rate=5)
    run_mode = 1'b1;
    rate     = 8'd5;
    step(2);
    n = cyc;
    key_in = 1'b1;
    sb.push_back(n + 13);
    sb.push_back(n + 19);
    step(7);
    key_in = 1'b0;
    step(11);
    key_in = 1'b1;
    step(7);
    check("prio_running", {31'd0, running}, 32'd0);
    check("prio_en", {31'd0, en}, 32'd0);
    key_in = 1'b0;
    step(10);

    // Reset mid-period in RUN_ACTIVE
    rate = 8'd3;
    n = cyc;
    key_in = 1'b1;
    sb.push_back(n + 11);
    step(7);
    key_in = 1'b0;
    step(6);
    check("pre_clear_running", {31'd0, running}, 32'd1);
    clear = 1'b0;
    step(1);
    check("clear_running", {31'd0, running}, 32'd0);
    check("clear_en", {31'd0, en}, 32'd0);
    clear = 1'b1;
    step(12);

    // Long hold in step mode: one pulse, plus repeats when auto-repeat is built in
    run_mode = 1'b0;
    step(2);
    n = cyc;
    key_in = 1'b1;
    sb.push_back(n + 7);
`ifdef CNT_AUTOREPEAT_EN
    sb.push_back(n + 15);
    sb.push_back(n + 19);
    sb.push_back(n + 23);
    sb.push_back(n + 27);
`endif
    step(22);
    key_in = 1'b0;
    step(20);

    while (sb.size() > 0) begin
      n_checks++;
      n = sb.pop_front();
      $display("FAIL en_missing: no pulse after edge %0d, expected one", n);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
